// File: rtl/serial_loader_pkg.sv
// Shared definitions for the serial loader.
//   - ldr_state_t : parser state encoding (3 bits)
//   - CHR_*       : ASCII framing characters of the dump record format
package serial_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE = 3'd0,
    LDR_ADDR = 3'd1,
    LDR_DHI  = 3'd2,
    LDR_DLO  = 3'd3,
    LDR_WR   = 3'd4
  } ldr_state_t;

  localparam logic [7:0] CHR_DOLLAR = 8'h24;
  localparam logic [7:0] CHR_HASH   = 8'h23;
  localparam logic [7:0] CHR_SPACE  = 8'h20;
  localparam logic [7:0] CHR_CR     = 8'h0D;

endpackage

// File: rtl/serial_loader_hex_char_decode.sv
// Combinational ASCII hex digit classifier.
//   ch     : input ASCII character
//   is_hex : ch is a hex digit
//   value  : 4-bit digit value (0 when is_hex is low)
// Build option: SERIAL_LOADER_LOWERCASE_EN also accepts 'a'-'f'.
module hex_char_decode (
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic [3:0] value
);

  always_comb begin
    is_hex = 1'b0;
    value  = 4'd0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      value  = ch[3:0];
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      // 'A' is 0x41, so the low nibble plus 9 gives 10..15
      is_hex = 1'b1;
      value  = ch[3:0] + 4'd9;
    end
`ifdef SERIAL_LOADER_LOWERCASE_EN
    else if (ch >= 8'h61 && ch <= 8'h66) begin
      is_hex = 1'b1;
      value  = ch[3:0] + 4'd9;
    end
`endif
  end

endmodule

// File: rtl/serial_loader.sv
// Serial hex record loader: parses "$AAAA#HH HH ... HH<CR>" records arriving
// one ASCII character per handshake and turns each data byte into a RAM write.
//   clk_1_43Hz : clock, rising edge
//   RESET      : asynchronous, active-high reset
//   rx_data    : received ASCII character
//   rx_valid   : rx_data valid
//   rx_ready   : loader accepts rx_data this cycle (low only in the write cycle)
//   wr_en      : one-cycle RAM write strobe
//   wr_addr    : RAM byte address, stable while wr_en is high
//   wr_data    : RAM write data, stable while wr_en is high
//   busy       : a record is in progress
//   err        : sticky record error, cleared by the next '$' or RESET
//   rec_done   : one-cycle pulse on a record ending cleanly with CR
//   byte_cnt   : bytes written in the current/last record
// Build option: SERIAL_LOADER_LOWERCASE_EN (lowercase hex digits, see decoder).
//
// Handshake: a character is consumed on a rising edge where rx_valid and
// rx_ready are both high; rx_data/rx_valid are ignored otherwise, and the
// sender must hold rx_data stable until it is consumed.
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 8,
  parameter int ADDR_DIGITS = 4
) (
  input  logic              clk_1_43Hz,
  input  logic              RESET,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              err,
  output logic              rec_done,
  output logic [7:0]        byte_cnt
);

  // The address shifter only needs the digits that can still reach wr_addr:
  // bits above ADDR_W would be truncated anyway, so keep the narrower width.
  localparam int SH_W = (ADDR_W < 4 * ADDR_DIGITS) ? ADDR_W : 4 * ADDR_DIGITS;

  ldr_state_t      state;
  logic [SH_W-1:0] addr_sh;
  logic [3:0]      nib;

  logic            is_hex;
  logic [3:0]      hex_val;
  logic            accept;

  hex_char_decode u_dec (
    .ch     (rx_data),
    .is_hex (is_hex),
    .value  (hex_val)
  );

  assign accept = rx_valid & rx_ready;

  always_ff @(posedge clk_1_43Hz or posedge RESET) begin
    if (RESET) begin
      state    <= LDR_IDLE;
      rx_ready <= 1'b1;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      rec_done <= 1'b0;
      byte_cnt <= 8'd0;
      addr_sh  <= '0;
      nib      <= 4'd0;
    end else begin
      wr_en    <= 1'b0;
      rec_done <= 1'b0;

      if (state == LDR_WR) begin
        // Write strobe has been visible for exactly this cycle; advance.
        wr_addr  <= wr_addr + 1'b1;
        byte_cnt <= byte_cnt + 8'd1;
        state    <= LDR_DHI;
        rx_ready <= 1'b1;
      end else if (accept) begin
        if (rx_data == CHR_DOLLAR) begin
          // Start of record restarts parsing from any state.
          state    <= LDR_ADDR;
          busy     <= 1'b1;
          addr_sh  <= '0;
          byte_cnt <= 8'd0;
          err      <= 1'b0;
        end else begin
          case (state)
            LDR_IDLE: begin
              // Text between records is ignored.
            end
            LDR_ADDR: begin
              if (is_hex) begin
                addr_sh <= SH_W'({addr_sh, hex_val});
              end else if (rx_data == CHR_HASH) begin
                wr_addr <= ADDR_W'(addr_sh);
                state   <= LDR_DHI;
              end else begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= LDR_IDLE;
              end
            end
            LDR_DHI: begin
              if (is_hex) begin
                nib   <= hex_val;
                state <= LDR_DLO;
              end else if (rx_data == CHR_SPACE) begin
                // Byte separator.
              end else if (rx_data == CHR_CR) begin
                rec_done <= 1'b1;
                busy     <= 1'b0;
                state    <= LDR_IDLE;
              end else begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= LDR_IDLE;
              end
            end
            LDR_DLO: begin
              if (is_hex) begin
                wr_data  <= DATA_W'({nib, hex_val});
                wr_en    <= 1'b1;
                rx_ready <= 1'b0;
                state    <= LDR_WR;
              end else begin
                // Includes CR: the record had an odd nibble count.
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= LDR_IDLE;
              end
            end
            default: begin
              busy     <= 1'b0;
              rx_ready <= 1'b1;
              state    <= LDR_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader: directed records plus random record
// streams, compared against a record-level parsing model.
module tb_serial_loader;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int W      = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic              clk_1_43Hz = 1'b0;
  logic              RESET;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              err;
  logic              rec_done;
  logic [7:0]        byte_cnt;

  always #5 clk_1_43Hz = ~clk_1_43Hz;

  serial_loader dut (
    .clk_1_43Hz (clk_1_43Hz),
    .RESET      (RESET),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .err        (err),
    .rec_done   (rec_done),
    .byte_cnt   (byte_cnt)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];     // expected {addr, data} writes in order
  logic [7:0]   stim_q[$];    // characters of the current stream
  int m_err   = 0;
  int m_busy  = 0;
  int m_bcnt  = 0;
  int m_done  = 0;            // cumulative clean record ends

  function automatic int hex_val_m(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
`ifdef SERIAL_LOADER_LOWERCASE_EN
    if (c >= "a" && c <= "f") return int'(c) - 87;
`endif
    return -1;
  endfunction

  // One record: characters stim_q[b .. e-1] following a '$'. e is either the
  // end of the stream or the index of the next '$'.
  task automatic model_record(input int b, input int e);
    int k;
    int a;
    int addr;
    int hi;
    int lo;
    k = b;
    a = 0;
    m_err  = 0;
    m_bcnt = 0;
    m_busy = 1;
    while (k < e && hex_val_m(stim_q[k]) >= 0) begin
      a = (a * 16 + hex_val_m(stim_q[k])) % 65536;
      k++;
    end
    if (k == e) return;
    if (stim_q[k] != 8'h23) begin m_err = 1; m_busy = 0; return; end
    k++;
    addr = a % (1 << ADDR_W);
    forever begin
      while (k < e && stim_q[k] == 8'h20) k++;
      if (k == e) return;
      if (stim_q[k] == 8'h0D) begin m_done++; m_busy = 0; return; end
      hi = hex_val_m(stim_q[k]);
      if (hi < 0) begin m_err = 1; m_busy = 0; return; end
      if (k + 1 == e) return;
      lo = hex_val_m(stim_q[k+1]);
      if (lo < 0) begin m_err = 1; m_busy = 0; return; end
      exp_q.push_back(W'(addr * 256 + hi * 16 + lo));
      addr   = (addr + 1) % (1 << ADDR_W);
      m_bcnt = (m_bcnt + 1) % 256;
      k += 2;
    end
  endtask

  task automatic model_stream();
    int i;
    int e;
    i = 0;
    while (i < stim_q.size()) begin
      if (stim_q[i] != 8'h24) begin
        i++;
      end else begin
        e = i + 1;
        while (e < stim_q.size() && stim_q[e] != 8'h24) e++;
        model_record(i + 1, e);
        i = e;
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  bit          mon_en = 1'b0;
  int          done_seen = 0;
  logic [31:0] mon_exp;

  always @(negedge clk_1_43Hz) begin
    if (mon_en) begin
      chk_eq("ready_low_only_in_wr", rx_ready, !wr_en);
      chk_eq("done_with_wr", rec_done & wr_en, 0);
      if (wr_en) begin
        mon_exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
        chk_eq("wr_addr_data", {13'd0, wr_addr, wr_data}, mon_exp);
      end
      if (rec_done) done_seen++;
    end
  end

  // ---------------- driver ----------------
  task automatic send_char(input logic [7:0] c, input bit b2b);
    int waited;
    if (!b2b) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk_1_43Hz);
    end
    rx_data  = c;
    rx_valid = 1'b1;
    waited   = 0;
    while (!rx_ready && waited < 4) begin
      @(negedge clk_1_43Hz);
      waited++;
    end
    chk_eq("rx_ready_wait", rx_ready, 1);
    @(negedge clk_1_43Hz);
  endtask

  // '~' stands for CR in directed strings.
  task automatic load_str(input string s);
    stim_q.delete();
    for (int i = 0; i < s.len(); i++)
      stim_q.push_back((s[i] == "~") ? 8'h0D : s[i]);
  endtask

  task automatic run_stream(input bit b2b);
    model_stream();
    for (int i = 0; i < stim_q.size(); i++) send_char(stim_q[i], b2b);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk_1_43Hz);
    chk_eq("writes_missing", exp_q.size(), 0);
    chk_eq("err", err, m_err);
    chk_eq("busy", busy, m_busy);
    chk_eq("byte_cnt", byte_cnt, m_bcnt);
    chk_eq("rec_done_cnt", done_seen, m_done);
    exp_q.delete();
  endtask

  task automatic check_reset_vals();
    chk_eq("rst_rx_ready", rx_ready, 1);
    chk_eq("rst_wr_en", wr_en, 0);
    chk_eq("rst_wr_addr", wr_addr, 0);
    chk_eq("rst_wr_data", wr_data, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_err", err, 0);
    chk_eq("rst_rec_done", rec_done, 0);
    chk_eq("rst_byte_cnt", byte_cnt, 0);
  endtask

  // ---------------- random record generator ----------------
  string      hex_chars = "0123456789ABCDEFabcdef";
  logic [7:0] junk_tab[8] = '{8'h47, 8'h7A, 8'h20, 8'h23, 8'h0D, 8'h2E, 8'h61, 8'h24};

  function automatic logic [7:0] pick_hex();
    int idx;
    idx = $urandom_range(0, 21);
    return hex_chars[idx];
  endfunction

  task automatic gen_random();
    int nd;
    int nb;
    stim_q.delete();
    stim_q.push_back(8'h24);
    nd = $urandom_range(0, 6);
    for (int i = 0; i < nd; i++) stim_q.push_back(pick_hex());
    if ($urandom_range(0, 9) != 0) stim_q.push_back(8'h23);
    else stim_q.push_back(junk_tab[$urandom_range(0, 7)]);
    nb = $urandom_range(0, 5);
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 2) == 0) stim_q.push_back(8'h20);
      stim_q.push_back(pick_hex());
      stim_q.push_back(pick_hex());
      if ($urandom_range(0, 11) == 0) stim_q.push_back(junk_tab[$urandom_range(0, 7)]);
    end
    if ($urandom_range(0, 9) != 0) stim_q.push_back(8'h0D);
    if ($urandom_range(0, 3) == 0) stim_q.push_back(junk_tab[$urandom_range(0, 6)]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RESET    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk_1_43Hz);
    check_reset_vals();
    RESET  = 1'b0;
    @(negedge clk_1_43Hz);
    mon_en = 1'b1;

    load_str("$0030#AA 55~");  run_stream(1'b0);
    load_str("$12345#01~");    run_stream(1'b0);
    load_str("$07FF#11 22~");  run_stream(1'b0);
    load_str("$0010#A~");      run_stream(1'b0);
    load_str("$0010#BB~");     run_stream(1'b0);
    load_str("$#C3~");         run_stream(1'b0);
    load_str("$0000#FFEE~");   run_stream(1'b1);
    load_str("$0000#ab~");     run_stream(1'b0);

    for (int n = 0; n < 60; n++) begin
      gen_random();
      run_stream(1'(($urandom_range(0, 1))));
    end

    // Reset while a write is pending: the write strobe must drop at once.
    mon_en = 1'b0;
    load_str("$0123#5A");
    for (int i = 0; i < stim_q.size(); i++) send_char(stim_q[i], 1'b1);
    chk_eq("pre_reset_wr_en", wr_en, 1);
    #2 RESET = 1'b1;
    #1 check_reset_vals();
    rx_valid = 1'b0;
    @(negedge clk_1_43Hz);
    RESET = 1'b0;
    @(negedge clk_1_43Hz);
    exp_q.delete();
    mon_en = 1'b1;

    load_str("$0005#5A~");     run_stream(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
